// File: rtl/fetch_word_server.sv
// Single-word instruction fetch server with a current-word cache and optional next-word prefetch.
// Build option: define FETCH_PREFETCH_EN to include the prefetch register and PREFETCH state.
module fetch_word_server #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        fetch_req,
    input  logic [31:0] imem_pc,
    input  logic        reset_en,
    output logic [31:0] inst,
    output logic        inst_arrived,
    output logic [31:0] bus_addr,
    output logic        bus_ren,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FETCH    = 2'd1;
`ifdef FETCH_PREFETCH_EN
    localparam logic [1:0] PREFETCH = 2'd2;
`endif
    localparam logic [1:0] DRAIN    = 2'd3;
    localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

    logic [1:0]  state_reg, state_next;
    logic [31:0] bus_addr_reg, bus_addr_next;
    logic [31:0] inst_reg, inst_next;
    logic        inst_arrived_reg, inst_arrived_next;
    logic [31:0] cur_addr_reg, cur_addr_next;
    logic [31:0] cur_data_reg, cur_data_next;
    logic        cur_valid_reg, cur_valid_next;
`ifdef FETCH_PREFETCH_EN
    logic [31:0] pf_addr_reg, pf_addr_next;
    logic [31:0] pf_data_reg, pf_data_next;
    logic        pf_valid_reg, pf_valid_next;
    logic        pf_hit;
`endif
    logic [31:0] pc_aligned;
    logic        req_ok;
    logic        cur_hit;

    assign pc_aligned = imem_pc & ~32'h0000_0003;
    // The cycle carrying a pulse is skipped so the fetch buffer can move imem_pc.
    assign req_ok  = fetch_req && !reset_en && !inst_arrived_reg;
    assign cur_hit = cur_valid_reg && (cur_addr_reg == pc_aligned);
`ifdef FETCH_PREFETCH_EN
    assign pf_hit  = pf_valid_reg && (pf_addr_reg == pc_aligned);
`endif

    always_comb begin
        state_next        = state_reg;
        bus_addr_next     = bus_addr_reg;
        inst_next         = inst_reg;
        inst_arrived_next = 1'b0;
        cur_addr_next     = cur_addr_reg;
        cur_data_next     = cur_data_reg;
        cur_valid_next    = cur_valid_reg;
`ifdef FETCH_PREFETCH_EN
        pf_addr_next      = pf_addr_reg;
        pf_data_next      = pf_data_reg;
        pf_valid_next     = pf_valid_reg;
`endif
        if (reset_en) begin
            cur_valid_next = 1'b0;
`ifdef FETCH_PREFETCH_EN
            pf_valid_next  = 1'b0;
`endif
        end
        case (state_reg)
            IDLE: begin
                if (req_ok) begin
                    if (cur_hit) begin
                        inst_next         = cur_data_reg;
                        inst_arrived_next = 1'b1;
`ifdef FETCH_PREFETCH_EN
                    end else if (pf_hit) begin
                        inst_next         = pf_data_reg;
                        inst_arrived_next = 1'b1;
                        cur_addr_next     = pf_addr_reg;
                        cur_data_next     = pf_data_reg;
                        cur_valid_next    = 1'b1;
                        pf_valid_next     = 1'b0;
                        bus_addr_next     = pf_addr_reg + 32'd4;
                        state_next        = PREFETCH;
`endif
                    end else begin
                        bus_addr_next = pc_aligned;
                        state_next    = FETCH;
                    end
                end
            end
            FETCH: begin
                if (reset_en) begin
                    state_next = bus_busy ? DRAIN : IDLE;
                end else if (!bus_busy) begin
                    inst_next         = bus_rdata;
                    inst_arrived_next = 1'b1;
                    cur_addr_next     = bus_addr_reg;
                    cur_data_next     = bus_rdata;
                    cur_valid_next    = 1'b1;
`ifdef FETCH_PREFETCH_EN
                    bus_addr_next     = bus_addr_reg + 32'd4;
                    state_next        = PREFETCH;
`else
                    state_next        = IDLE;
`endif
                end
            end
`ifdef FETCH_PREFETCH_EN
            PREFETCH: begin
                if (reset_en) begin
                    state_next = bus_busy ? DRAIN : IDLE;
                end else if (!bus_busy) begin
                    if (req_ok && pc_aligned == bus_addr_reg) begin
                        // Demand caught up with the prefetch: deliver and keep streaming.
                        inst_next         = bus_rdata;
                        inst_arrived_next = 1'b1;
                        cur_addr_next     = bus_addr_reg;
                        cur_data_next     = bus_rdata;
                        cur_valid_next    = 1'b1;
                        pf_valid_next     = 1'b0;
                        bus_addr_next     = bus_addr_reg + 32'd4;
                        state_next        = PREFETCH;
                    end else begin
                        pf_addr_next  = bus_addr_reg;
                        pf_data_next  = bus_rdata;
                        pf_valid_next = 1'b1;
                        if (req_ok) begin
                            bus_addr_next = pc_aligned;
                            state_next    = FETCH;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
`endif
            DRAIN: begin
                if (!bus_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_reg        <= IDLE;
            bus_addr_reg     <= RESET_ADDR;
            inst_reg         <= '0;
            inst_arrived_reg <= 1'b0;
            cur_addr_reg     <= '0;
            cur_data_reg     <= '0;
            cur_valid_reg    <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            pf_addr_reg      <= '0;
            pf_data_reg      <= '0;
            pf_valid_reg     <= 1'b0;
`endif
        end else begin
            state_reg        <= state_next;
            bus_addr_reg     <= bus_addr_next;
            inst_reg         <= inst_next;
            inst_arrived_reg <= inst_arrived_next;
            cur_addr_reg     <= cur_addr_next;
            cur_data_reg     <= cur_data_next;
            cur_valid_reg    <= cur_valid_next;
`ifdef FETCH_PREFETCH_EN
            pf_addr_reg      <= pf_addr_next;
            pf_data_reg      <= pf_data_next;
            pf_valid_reg     <= pf_valid_next;
`endif
        end
    end

    assign inst         = inst_reg;
    assign inst_arrived = inst_arrived_reg;
    assign bus_addr     = bus_addr_reg;
    assign bus_ren      = (state_reg != IDLE);

endmodule

// File: tb/tb_fetch_word_server.sv
// Scoreboard bench for fetch_word_server: expected words are queued per demand request and
// popped by a monitor on every inst_arrived pulse; a bus responder serves a static memory image.
module tb_fetch_word_server;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        fetch_req;
    logic [31:0] imem_pc;
    logic        reset_en;
    logic [31:0] inst;
    logic        inst_arrived;
    logic [31:0] bus_addr;
    logic        bus_ren;
    logic [31:0] bus_rdata;
    logic        bus_busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int lat_force = -1;
    logic [31:0] exp_q[$];

    fetch_word_server #(.RESET_PC(32'h0000_0200)) dut (
        .clk(clk), .n_rst(n_rst), .fetch_req(fetch_req), .imem_pc(imem_pc),
        .reset_en(reset_en), .inst(inst), .inst_arrived(inst_arrived),
        .bus_addr(bus_addr), .bus_ren(bus_ren), .bus_rdata(bus_rdata), .bus_busy(bus_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0000_0200) return 32'h00A0_0093;
        return w * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        chk_cnt++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    endtask

    // Bus responder: random (or forced) wait states, then data from the memory image.
    initial begin : bus_model
        bit          active;
        int          wait_left;
        logic [31:0] xfer_addr;
        active = 0; wait_left = 0; xfer_addr = '0;
        bus_busy = 1'b1; bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus_ren !== 1'b1) begin
                active = 0;
                bus_busy = 1'b1;
            end else begin
                if (!active) begin
                    active = 1;
                    xfer_addr = bus_addr;
                    wait_left = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
                end
                if (wait_left == 0) begin
                    check("bus_addr_stable", bus_addr, xfer_addr);
                    check("bus_addr_aligned", {30'd0, bus_addr[1:0]}, 32'd0);
                    bus_rdata = mem_word(bus_addr);
                    bus_busy = 1'b0;
                    active = 0;
                    $display("bus read addr=%h data=%h", bus_addr, bus_rdata);
                end else begin
                    bus_busy = 1'b1;
                    bus_rdata = $urandom;
                    wait_left--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each pulse, checks inst holds between pulses.
    initial begin : monitor
        logic        prev_arr;
        logic [31:0] last_inst;
        logic [31:0] e;
        prev_arr = 1'b0; last_inst = '0;
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1) begin
                prev_arr = 1'b0;
                last_inst = '0;
            end else if (inst_arrived === 1'b1) begin
                check("no_back_to_back", {31'd0, prev_arr}, 32'd0);
                check("pulse_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("inst_data", inst, e);
                end
                $display("deliver inst=%h", inst);
                last_inst = inst;
                prev_arr = 1'b1;
            end else begin
                check("inst_hold", inst, last_inst);
                prev_arr = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        n_rst = 1'b1; fetch_req = 1'b0; reset_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_inst", inst, 32'h0);
        check("rst_arrived", {31'd0, inst_arrived}, 32'd0);
        check("rst_bus_ren", {31'd0, bus_ren}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0000_0200);
        n_rst = 1'b0;
    endtask

    task automatic do_request(input logic [31:0] pc, output int lat, output logic ren_seen,
                              output logic [31:0] first_addr, output logic ren_at_pulse,
                              output logic [31:0] addr_at_pulse);
        logic got;
        fetch_req = 1'b1; imem_pc = pc;
        exp_q.push_back(mem_word(pc));
        lat = 0; ren_seen = 1'b0; first_addr = '1; got = 1'b0;
        while (lat < 100 && !got) begin
            @(negedge clk);
            lat++;
            if (inst_arrived === 1'b1) got = 1'b1;
            else if (bus_ren === 1'b1 && !ren_seen) begin
                ren_seen = 1'b1;
                first_addr = bus_addr;
            end
        end
        ren_at_pulse = bus_ren;
        addr_at_pulse = bus_addr;
        check("request_served", {31'd0, got}, 32'd1);
        if (!got) exp_q.delete();
        $display("request pc=%h latency=%0d bus_used=%0b", pc, lat, ren_seen);
        fetch_req = 1'b0;
    endtask

    task automatic wait_quiet();
        int n;
        fetch_req = 1'b0;
        @(negedge clk);
        n = 0;
        while (bus_ren === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bus_quiet", {31'd0, bus_ren}, 32'd0);
    endtask

    task automatic wait_ren();
        int n;
        n = 0;
        while (bus_ren !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bus_ren_start", {31'd0, bus_ren}, 32'd1);
    endtask

    initial begin : stim
        int          lat;
        logic        rs, rp;
        logic [31:0] fa, ap, pc;
        int          pulses, r;
        n_rst = 1'b1; fetch_req = 1'b0; reset_en = 1'b0; imem_pc = '0;

        // Basic miss from reset, two wait states.
        do_reset();
        lat_force = 2;
        do_request(32'h0000_0200, lat, rs, fa, rp, ap);
        check("first_bus_addr", fa, 32'h0000_0200);
        lat_force = -1;

        // Repeat in the same word is served from cur without the bus.
        wait_quiet();
        do_request(32'h0000_0202, lat, rs, fa, rp, ap);
        check("cur_hit_latency", lat, 32'd1);
        check("cur_hit_no_bus", {31'd0, rs}, 32'd0);
        check("cur_hit_ren_pulse", {31'd0, rp}, 32'd0);

        wait_quiet();
        do_request(32'h0000_0204, lat, rs, fa, rp, ap);
`ifdef FETCH_PREFETCH_EN
        check("pf_hit_latency", lat, 32'd1);
        check("pf_hit_no_bus", {31'd0, rs}, 32'd0);
        check("pf_next_ren", {31'd0, rp}, 32'd1);
        check("pf_next_addr", ap, 32'h0000_0208);
`else
        check("miss_bus_addr", fa, 32'h0000_0204);
        check("fetch_returns_idle", {31'd0, rp}, 32'd0);
`endif

        // Redirect while a fetch is busy: drain, no pulse, then serve the new target.
        do_reset();
        lat_force = 6;
        fetch_req = 1'b1; imem_pc = 32'h0000_0200;
        wait_ren();
        @(negedge clk);
        reset_en = 1'b1; imem_pc = 32'h0000_0300; fetch_req = 1'b0;
        @(negedge clk);
        reset_en = 1'b0;
        check("drain_ren_held", {31'd0, bus_ren}, 32'd1);
        check("drain_addr_held", bus_addr, 32'h0000_0200);
        pulses = 0;
        for (int n = 0; n < 50 && bus_ren === 1'b1; n++) begin
            @(negedge clk);
            if (inst_arrived === 1'b1) pulses++;
        end
        check("drain_no_pulse", pulses, 32'd0);
        lat_force = -1;
        do_request(32'h0000_0300, lat, rs, fa, rp, ap);
        check("redirect_bus_addr", fa, 32'h0000_0300);

        // Flush in IDLE invalidates cur.
        wait_quiet();
        reset_en = 1'b1;
        @(negedge clk);
        reset_en = 1'b0;
        do_request(32'h0000_0300, lat, rs, fa, rp, ap);
        check("flush_forces_bus", {31'd0, rs}, 32'd1);

        // Top of address space.
        wait_quiet();
        do_request(32'hFFFF_FFFC, lat, rs, fa, rp, ap);
`ifdef FETCH_PREFETCH_EN
        check("wrap_pf_ren", {31'd0, rp}, 32'd1);
        check("wrap_pf_addr", ap, 32'h0000_0000);
        wait_quiet();
        do_request(32'h0000_0000, lat, rs, fa, rp, ap);
        check("wrap_pf_hit", {31'd0, rs}, 32'd0);
`else
        check("wrap_fetch_idle", {31'd0, rp}, 32'd0);
`endif

        // Reset in the middle of a busy fetch.
        wait_quiet();
        lat_force = 10;
        fetch_req = 1'b1; imem_pc = 32'h0000_0600;
        wait_ren();
        @(negedge clk);
        n_rst = 1'b1; fetch_req = 1'b0;
        @(negedge clk);
        check("midrst_ren", {31'd0, bus_ren}, 32'd0);
        check("midrst_arrived", {31'd0, inst_arrived}, 32'd0);
        check("midrst_inst", inst, 32'h0);
        n_rst = 1'b0;
        lat_force = -1;
        @(negedge clk);
        do_request(32'hFFFF_FFFC, lat, rs, fa, rp, ap);
        check("midrst_cur_cleared", {31'd0, rs}, 32'd1);

        // Random instruction stream with repeats, jumps, idle gaps and redirects.
        wait_quiet();
        pc = 32'h0000_1000;
        for (int t = 0; t < 200; t++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                reset_en = 1'b1; fetch_req = 1'b0;
                @(negedge clk);
                reset_en = 1'b0;
                pc = 32'h0000_1000 + {$urandom_range(0, 63), 2'b00};
            end else if (r < 15) begin
                fetch_req = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
            if (r % 5 == 0) pc = pc;
            else if (r < 20) pc = 32'h0000_1000 + {$urandom_range(0, 63), 2'b00};
            else if (r < 23) pc = 32'hFFFF_FFF8;
            else pc = pc + 32'd4;
            do_request(pc | 32'($urandom_range(0, 3)), lat, rs, fa, rp, ap);
        end

        wait_quiet();
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_word_server.md
FETCH_WORD_SERVER -- requirements
Module: fetch_word_server

Interface
REQ-001 The module SHALL have one clock and one reset: clk input 1, rising-edge clock; n_rst input 1, synchronous, active-high reset.
REQ-002 The module SHALL have these fetch-side ports: fetch_req input 1, fetch buffer wants a word; imem_pc input 32, requested word address (bits[1:0] ignored); reset_en input 1, redirect/flush; inst output 32, returned word; inst_arrived output 1, one-cycle valid pulse for inst.
REQ-003 The module SHALL have these bus-side ports: bus_addr output 32, word-aligned read address; bus_ren output 1, read request; bus_rdata input 32, read data; bus_busy input 1, low means bus_rdata is valid and the transfer is complete.
REQ-004 The module SHALL have one parameter: RESET_PC, default 32'h0000_0200, initial word address (bits[1:0] forced 0).

Function
REQ-005 The module SHALL keep a current-word register (cur_addr, cur_data, cur_valid) and a prefetch register (pf_addr, pf_data, pf_valid).
REQ-006 The FSM SHALL have exactly the states IDLE, FETCH, PREFETCH and DRAIN.
REQ-007 IDLE, with fetch_req=1, reset_en=0, inst_arrived=0 and a hit on cur_valid and imem_pc[31:2]==cur_addr[31:2]: next cycle inst=cur_data, inst_arrived=1, no bus access.
REQ-008 IDLE, pf hit (pf_valid, imem_pc[31:2]==pf_addr[31:2]): next cycle inst=pf_data, inst_arrived=1; cur<=pf; pf_valid<=0; go to PREFETCH for pf_addr+4.
REQ-009 IDLE, miss: go to FETCH; bus_addr={imem_pc[31:2],2'b00} latched.
REQ-010 In FETCH and PREFETCH, bus_ren=1 and bus_addr SHALL remain stable until the cycle bus_busy=0 is sampled.
REQ-011 FETCH completion (bus_busy=0): next cycle inst=bus_rdata, inst_arrived=1, cur<=(addr,data,1); then go to PREFETCH for addr+4 if prefetch is enabled, else IDLE.
REQ-012 PREFETCH completion: pf<=(addr,data,1); go to IDLE; no inst_arrived unless REQ-013 applies.
REQ-013 A demand request during PREFETCH matching the prefetch address SHALL be served with inst_arrived one cycle after completion, with cur<=fetched word and pf_valid=0; a non-matching request SHALL wait for completion, then go to FETCH.
REQ-014 inst_arrived SHALL never be asserted on two consecutive cycles; IDLE SHALL ignore requests in the cycle inst_arrived=1, so the fetch buffer can update imem_pc.
REQ-015 inst SHALL hold its last delivered value between pulses.
REQ-016 Address arithmetic SHALL be 32-bit modulo 2^32; prefetch of 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-017 reset_en in IDLE SHALL clear cur_valid and pf_valid and suppress any response in the following cycle.
REQ-018 reset_en in FETCH or PREFETCH SHALL clear cur_valid and pf_valid and go to DRAIN; DRAIN holds bus_ren/bus_addr until bus_busy=0, discards the data, and goes to IDLE with no inst_arrived.
REQ-019 reset_en takes priority over a same-cycle bus completion: the data SHALL be discarded and the FSM go to IDLE.

Reset
REQ-020 With n_rst=1 at a clk edge: state=IDLE, cur_valid=0, pf_valid=0, inst=0, inst_arrived=0, bus_ren=0, bus_addr=RESET_PC.
REQ-021 Reset asserted mid-transaction SHALL abandon the transfer immediately, with bus_ren=0 the next cycle.

Configuration
REQ-022 Macro FETCH_PREFETCH_EN defined: the PREFETCH state and the pf register SHALL exist as specified.
REQ-023 Macro FETCH_PREFETCH_EN undefined: there SHALL be no pf register or PREFETCH state, FETCH SHALL always return to IDLE, and the cur hit (REQ-007) SHALL still apply.

Verification
REQ-024 Reset, fetch_req=1, imem_pc=0x200, bus_busy low after 2 cycles, rdata=0x00A00093 -> bus_addr=0x200, inst=0x00A00093, one inst_arrived pulse.
REQ-025 Repeat request for 0x202 after delivering 0x200 -> inst_arrived the next cycle from cur, bus_ren stays 0.
REQ-026 With FETCH_PREFETCH_EN, deliver 0x200, prefetch of 0x204 completes, request 0x204 -> hit with 1-cycle latency, bus read of 0x208 starts.
REQ-027 reset_en to 0x300 while the FETCH of 0x200 is busy -> bus_ren held until busy low, no pulse, then bus_addr=0x300 and delivery of the 0x300 word.
REQ-028 Prefetch at 0xFFFFFFFC -> bus_addr=0x00000000 for the prefetch.
REQ-029 n_rst=1 during a FETCH with bus_busy=1 -> bus_ren=0 and inst_arrived=0 next cycle, with all valid bits cleared.
